// File: rtl/apb_protocol_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : apb_protocol_monitor                                            |
// | Passive APB phase tracker flagging protocol violations, with first-error |
// | capture and saturating transfer statistics.                              |
// | Optional: define APB_MON_STRB_CHECK_EN to flag reads with pstrb != 0.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module apb_protocol_monitor #(
    parameter int ADDR_WIDTH = 32,
    parameter int BUS_WIDTH  = 32,
    parameter int NUM_SLV    = 1,
    parameter int TIMEOUT    = 16,
    parameter int CNT_W      = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SLV-1:0]     psel,
    input  logic                   penable,
    input  logic                   pwrite,
    input  logic [ADDR_WIDTH-1:0]  paddr,
    input  logic [BUS_WIDTH-1:0]   pwdata,
    input  logic [BUS_WIDTH/8-1:0] pstrb,
    input  logic                   pready,
    input  logic                   pslverr,
    input  logic                   clr,
    output logic [6:0]             err_pulse,
    output logic [6:0]             err_sticky,
    output logic [2:0]             err_first_code,
    output logic [ADDR_WIDTH-1:0]  err_first_addr,
    output logic                   xfer_done,
    output logic [CNT_W-1:0]       wr_cnt,
    output logic [CNT_W-1:0]       rd_cnt,
    output logic [CNT_W-1:0]       slverr_cnt
);

    localparam int             c_WAIT_W   = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_TIMEOUT = c_WAIT_W'(TIMEOUT);
    localparam logic [1:0]     c_S_IDLE   = 2'd0;
    localparam logic [1:0]     c_S_SETUP  = 2'd1;
    localparam logic [1:0]     c_S_ACCESS = 2'd2;
    localparam int             c_E_PHASE   = 0;
    localparam int             c_E_STABLE  = 1;
    localparam int             c_E_TIMEOUT = 2;
    localparam int             c_E_ENABLE  = 3;
    localparam int             c_E_ONEHOT  = 4;
    localparam int             c_E_SLVERR  = 5;

    logic [1:0]             r_state;
    logic [c_WAIT_W-1:0]    r_wait;
    logic [NUM_SLV-1:0]     r_cap_psel;
    logic [ADDR_WIDTH-1:0]  r_cap_paddr;
    logic                   r_cap_pwrite;
    logic [BUS_WIDTH-1:0]   r_cap_pwdata;
    logic [BUS_WIDTH/8-1:0] r_cap_pstrb;

    logic                   w_sel;
    logic                   w_stable_err;
    logic [6:0]             w_err;
    logic [1:0]             w_next_state;
    logic [c_WAIT_W-1:0]    w_next_wait;
    logic                   w_capture;
    logic                   w_complete;

    function automatic logic [2:0] f_lowest(input logic [6:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign w_sel        = |psel;
    assign w_stable_err = (psel != r_cap_psel) || (paddr != r_cap_paddr) ||
                          (pwrite != r_cap_pwrite) || (pwdata != r_cap_pwdata) ||
                          (pstrb != r_cap_pstrb);

    always_comb begin
        w_err        = '0;
        w_next_state = r_state;
        w_next_wait  = r_wait;
        w_capture    = 1'b0;
        w_complete   = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (penable) begin
                    w_err[c_E_ENABLE] = 1'b1;
                end else if (w_sel) begin
                    w_capture    = 1'b1;
                    w_next_state = c_S_SETUP;
                    w_next_wait  = '0;
                end
            end
            c_S_SETUP, c_S_ACCESS: begin
                if (w_sel && penable) begin
                    w_err[c_E_STABLE] = w_stable_err;
                    if (pready) begin
                        w_complete   = 1'b1;
                        w_next_state = c_S_IDLE;
                        w_next_wait  = '0;
                    end else if (r_state == c_S_SETUP) begin
                        w_next_state = c_S_ACCESS;
                        w_next_wait  = c_WAIT_W'(1);
                    end else if (r_wait == c_TIMEOUT) begin
                        w_err[c_E_TIMEOUT] = 1'b1;
                        w_next_state       = c_S_IDLE;
                        w_next_wait        = '0;
                    end else begin
                        w_next_wait = r_wait + c_WAIT_W'(1);
                    end
                end else begin
                    // A fresh setup phase here restarts tracking on the new transfer
                    w_err[c_E_PHASE] = 1'b1;
                    w_next_wait      = '0;
                    if (w_sel && !penable) begin
                        w_capture    = 1'b1;
                        w_next_state = c_S_SETUP;
                    end else begin
                        w_next_state = c_S_IDLE;
                    end
                end
`ifdef APB_MON_STRB_CHECK_EN
                if (!r_cap_pwrite && (pstrb != '0)) w_err[6] = 1'b1;
`endif
            end
            default: begin
                w_next_state = c_S_IDLE;
                w_next_wait  = '0;
            end
        endcase
        w_err[c_E_ONEHOT] = (psel & (psel - NUM_SLV'(1))) != '0;
        w_err[c_E_SLVERR] = pslverr && !w_complete;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= c_S_IDLE;
            r_wait         <= '0;
            r_cap_psel     <= '0;
            r_cap_paddr    <= '0;
            r_cap_pwrite   <= 1'b0;
            r_cap_pwdata   <= '0;
            r_cap_pstrb    <= '0;
            err_pulse      <= '0;
            err_sticky     <= '0;
            err_first_code <= '0;
            err_first_addr <= '0;
            xfer_done      <= 1'b0;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            slverr_cnt     <= '0;
        end else begin
            r_state   <= w_next_state;
            r_wait    <= w_next_wait;
            err_pulse <= w_err;
            xfer_done <= w_complete;
            if (w_capture) begin
                r_cap_psel   <= psel;
                r_cap_paddr  <= paddr;
                r_cap_pwrite <= pwrite;
                r_cap_pwdata <= pwdata;
                r_cap_pstrb  <= pstrb;
            end
            if (clr) begin
                err_sticky     <= '0;
                err_first_code <= '0;
                err_first_addr <= '0;
                wr_cnt         <= '0;
                rd_cnt         <= '0;
                slverr_cnt     <= '0;
            end else begin
                err_sticky <= err_sticky | w_err;
                if ((err_sticky == '0) && (w_err != '0)) begin
                    err_first_code <= f_lowest(w_err);
                    err_first_addr <= paddr;
                end
                if (w_complete) begin
                    if (r_cap_pwrite) begin
                        if (wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
                    end else begin
                        if (rd_cnt != '1) rd_cnt <= rd_cnt + CNT_W'(1);
                    end
                    if (pslverr && (slverr_cnt != '1)) slverr_cnt <= slverr_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_apb_protocol_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_apb_protocol_monitor                                         |
// | Vector-table bench for apb_protocol_monitor (NUM_SLV=2, TIMEOUT=4, CNT_W=2)|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_apb_protocol_monitor;

    localparam int c_AW = 32;
    localparam int c_BW = 32;
    localparam int c_NS = 2;
    localparam int c_TO = 4;
    localparam int c_CW = 2;
`ifdef APB_MON_STRB_CHECK_EN
    localparam logic [6:0] c_S = 7'h40;
`else
    localparam logic [6:0] c_S = 7'h00;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [c_NS-1:0]   psel;
    logic              penable, pwrite, pready, pslverr, clr;
    logic [c_AW-1:0]   paddr;
    logic [c_BW-1:0]   pwdata;
    logic [c_BW/8-1:0] pstrb;
    logic [6:0]        err_pulse, err_sticky;
    logic [2:0]        err_first_code;
    logic [c_AW-1:0]   err_first_addr;
    logic              xfer_done;
    logic [c_CW-1:0]   wr_cnt, rd_cnt, slverr_cnt;

    always #5 clk = ~clk;

    apb_protocol_monitor #(
        .ADDR_WIDTH(c_AW), .BUS_WIDTH(c_BW), .NUM_SLV(c_NS), .TIMEOUT(c_TO), .CNT_W(c_CW)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready),
        .pslverr(pslverr), .clr(clr), .err_pulse(err_pulse), .err_sticky(err_sticky),
        .err_first_code(err_first_code), .err_first_addr(err_first_addr),
        .xfer_done(xfer_done), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .slverr_cnt(slverr_cnt)
    );

    typedef struct {
        logic [1:0]  sel;
        logic        en, wr;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic        rdy, slv, clr;
        logic [6:0]  e_pulse, e_sticky;
        logic        e_done;
        logic [1:0]  e_wr, e_rd, e_slv;
    } vec_t;

    vec_t tbl[32];
    vec_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic vec_t mk(input logic [1:0] sel, input logic en, input logic wr,
                                input logic [31:0] addr, input logic [3:0] strb,
                                input logic rdy, input logic slv, input logic cl,
                                input logic [6:0] p, input logic [6:0] s, input logic d,
                                input logic [1:0] w, input logic [1:0] r, input logic [1:0] e);
        vec_t v;
        v.sel = sel; v.en = en; v.wr = wr; v.addr = addr; v.strb = strb;
        v.rdy = rdy; v.slv = slv; v.clr = cl;
        v.e_pulse = p; v.e_sticky = s; v.e_done = d; v.e_wr = w; v.e_rd = r; v.e_slv = e;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_vecs(input int lo, input int hi);
        vec_t e;
        for (int i = lo; i <= hi; i++) begin
            psel = tbl[i].sel; penable = tbl[i].en; pwrite = tbl[i].wr;
            paddr = tbl[i].addr; pstrb = tbl[i].strb; pready = tbl[i].rdy;
            pslverr = tbl[i].slv; clr = tbl[i].clr;
            sb_q.push_back(tbl[i]);
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                chk($sformatf("v%0d.scoreboard_empty", i), 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("v%0d.err_pulse", i),  64'(err_pulse),  64'(e.e_pulse));
                chk($sformatf("v%0d.err_sticky", i), 64'(err_sticky), 64'(e.e_sticky));
                chk($sformatf("v%0d.xfer_done", i),  64'(xfer_done),  64'(e.e_done));
                chk($sformatf("v%0d.wr_cnt", i),     64'(wr_cnt),     64'(e.e_wr));
                chk($sformatf("v%0d.rd_cnt", i),     64'(rd_cnt),     64'(e.e_rd));
                chk($sformatf("v%0d.slverr_cnt", i), 64'(slverr_cnt), 64'(e.e_slv));
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //           sel   en wr addr    strb rdy slv clr  pulse  sticky    done wr rd slv
        tbl[0]  = mk(2'b01,0,1,32'h10,4'h0,0,0,0, 7'h00,7'h00,      0,0,0,0);
        tbl[1]  = mk(2'b01,1,1,32'h10,4'h0,0,0,0, 7'h00,7'h00,      0,0,0,0);
        tbl[2]  = mk(2'b01,1,1,32'h10,4'h0,0,0,0, 7'h00,7'h00,      0,0,0,0);
        tbl[3]  = mk(2'b01,1,1,32'h10,4'h0,1,0,0, 7'h00,7'h00,      1,1,0,0);
        tbl[4]  = mk(2'b00,0,0,32'h00,4'h0,0,0,0, 7'h00,7'h00,      0,1,0,0);
        tbl[5]  = mk(2'b01,0,0,32'h20,4'h0,0,0,0, 7'h00,7'h00,      0,1,0,0);
        tbl[6]  = mk(2'b01,1,0,32'h20,4'h0,0,0,0, 7'h00,7'h00,      0,1,0,0);
        tbl[7]  = mk(2'b01,1,0,32'h24,4'h0,1,0,0, 7'h02,7'h02,      1,1,1,0);
        tbl[8]  = mk(2'b00,0,0,32'h00,4'h0,0,0,0, 7'h00,7'h02,      0,1,1,0);
        tbl[9]  = mk(2'b10,0,1,32'h30,4'h0,0,0,0, 7'h00,7'h02,      0,1,1,0);
        tbl[10] = mk(2'b10,1,1,32'h30,4'h0,0,0,0, 7'h00,7'h02,      0,1,1,0);
        tbl[11] = mk(2'b10,1,1,32'h30,4'h0,0,0,0, 7'h00,7'h02,      0,1,1,0);
        tbl[12] = mk(2'b10,1,1,32'h30,4'h0,0,0,0, 7'h00,7'h02,      0,1,1,0);
        tbl[13] = mk(2'b10,1,1,32'h30,4'h0,0,0,0, 7'h00,7'h02,      0,1,1,0);
        tbl[14] = mk(2'b10,1,1,32'h30,4'h0,0,0,0, 7'h04,7'h06,      0,1,1,0);
        tbl[15] = mk(2'b00,0,0,32'h00,4'h0,0,0,1, 7'h00,7'h00,      0,0,0,0);
        tbl[16] = mk(2'b00,1,0,32'h3C,4'h0,0,0,0, 7'h08,7'h08,      0,0,0,0);
        tbl[17] = mk(2'b11,0,0,32'h40,4'h0,0,0,0, 7'h10,7'h18,      0,0,0,0);
        tbl[18] = mk(2'b00,0,0,32'h00,4'h0,0,0,0, 7'h01,7'h19,      0,0,0,0);
        tbl[19] = mk(2'b01,0,0,32'h50,4'h0,0,0,0, 7'h00,7'h19,      0,0,0,0);
        tbl[20] = mk(2'b01,1,0,32'h50,4'h0,1,0,0, 7'h00,7'h19,      1,0,1,0);
        tbl[21] = mk(2'b01,0,0,32'h54,4'h0,0,0,0, 7'h00,7'h19,      0,0,1,0);
        tbl[22] = mk(2'b01,1,0,32'h54,4'h0,1,1,0, 7'h00,7'h19,      1,0,2,1);
        tbl[23] = mk(2'b01,0,0,32'h58,4'h0,0,0,0, 7'h00,7'h19,      0,0,2,1);
        tbl[24] = mk(2'b01,1,0,32'h58,4'h0,1,0,0, 7'h00,7'h19,      1,0,3,1);
        tbl[25] = mk(2'b01,0,0,32'h5C,4'h0,0,0,0, 7'h00,7'h19,      0,0,3,1);
        tbl[26] = mk(2'b01,1,0,32'h5C,4'h0,1,0,0, 7'h00,7'h19,      1,0,3,1);
        tbl[27] = mk(2'b00,0,0,32'h00,4'h0,0,1,0, 7'h20,7'h39,      0,0,3,1);
        tbl[28] = mk(2'b00,0,0,32'h00,4'h0,0,0,1, 7'h00,7'h00,      0,0,0,0);
        tbl[29] = mk(2'b01,0,0,32'h60,4'hF,0,0,0, 7'h00,7'h00,      0,0,0,0);
        tbl[30] = mk(2'b01,1,0,32'h60,4'hF,1,0,0, c_S,  c_S,        1,0,1,0);
        tbl[31] = mk(2'b00,0,0,32'h00,4'h0,0,0,0, 7'h00,c_S,        0,0,1,0);

        rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
        pwdata = '0; pstrb = '0; pready = 1'b0; pslverr = 1'b0; clr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.err_pulse",  64'(err_pulse),      64'd0);
        chk("reset.err_sticky", 64'(err_sticky),     64'd0);
        chk("reset.first_code", 64'(err_first_code), 64'd0);
        chk("reset.first_addr", 64'(err_first_addr), 64'd0);
        chk("reset.xfer_done",  64'(xfer_done),      64'd0);
        chk("reset.counts",     64'({wr_cnt, rd_cnt, slverr_cnt}), 64'd0);
        rst = 1'b0;

        run_vecs(0, 8);
        chk("stable.first_code", 64'(err_first_code), 64'd1);
        chk("stable.first_addr", 64'(err_first_addr), 64'h24);
        run_vecs(9, 17);
        chk("enable.first_code", 64'(err_first_code), 64'd3);
        chk("enable.first_addr", 64'(err_first_addr), 64'h3C);
        run_vecs(18, 28);
        chk("clr.first_code", 64'(err_first_code), 64'd0);
        chk("clr.first_addr", 64'(err_first_addr), 64'd0);
        run_vecs(29, 31);

        // Reset in the middle of an access: abandoned with no count and no error
        psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h70; pready = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1; pready = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.xfer_done",  64'(xfer_done),  64'd0);
        chk("midrst.wr_cnt",     64'(wr_cnt),     64'd0);
        chk("midrst.rd_cnt",     64'(rd_cnt),     64'd0);
        chk("midrst.err_pulse",  64'(err_pulse),  64'd0);
        chk("midrst.err_sticky", 64'(err_sticky), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst.err_pulse", 64'(err_pulse), 64'h08);
        chk("postrst.xfer_done", 64'(xfer_done), 64'd0);
        chk("postrst.wr_cnt",    64'(wr_cnt),    64'd0);
        psel = '0; penable = 1'b0; pready = 1'b0;
        @(posedge clk); #1;
        chk("postrst.idle_pulse", 64'(err_pulse), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
